// File: rtl/mac_accfix_if.sv
// Handshake bundle between the product stage, mac_accfix and the downstream consumer.
// The slave modport is the accumulator's view; the master modport is the surrounding datapath's view.
interface mac_accfix_if #(
  parameter int unsigned WP = 12,
  parameter int unsigned WO = 8,
  parameter int unsigned TW = 2
);
  logic [WP-1:0] prod;
  logic          prod_valid;
  logic          prod_ready;
  logic [TW-1:0] tap_idx;
  logic [WO-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          ovf;
  logic          busy;

  modport slave (
    input  prod, prod_valid, out_ready,
    output prod_ready, tap_idx, out_data, out_valid, ovf, busy
  );

  modport master (
    output prod, prod_valid, out_ready,
    input  prod_ready, tap_idx, out_data, out_valid, ovf, busy
  );
endinterface

// File: rtl/mac_accfix.sv
// Time-multiplexed FIR accumulator: sums NTAP fixed-point products, then re-quantises the
// sum with floor rounding and saturation, and holds it until the downstream handshake.
module mac_accfix #(
  parameter int WI_P = 4,
  parameter int WF_P = 8,
  parameter int WI_A = 8,
  parameter int WF_A = 8,
  parameter int WI_O = 4,
  parameter int WF_O = 4,
  parameter int NTAP = 4
) (
  input  logic          clk,
  input  logic          rst,
  mac_accfix_if.slave   bus
);
  localparam int WP  = WI_P + WF_P;
  localparam int WA  = WI_A + WF_A;
  localparam int WO  = WI_O + WF_O;
  localparam int TW  = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int LSH = (WF_O > WF_A) ? WF_O - WF_A : 0;
  localparam int RSH = (WF_A > WF_O) ? WF_A - WF_O : 0;
  localparam int WQ  = WA + LSH;
  localparam int WC  = ((WQ > WO) ? WQ : WO) + 1;
  localparam logic signed [WC-1:0] MaxC = WC'((64'sd1 <<< (WO - 1)) - 64'sd1);
  localparam logic signed [WC-1:0] MinC = WC'(-(64'sd1 <<< (WO - 1)));

  if (WI_A < WI_P) begin : gen_chk_wi
    $error("mac_accfix: WI_A must be >= WI_P");
  end
  if (WF_A < WF_P) begin : gen_chk_wf
    $error("mac_accfix: WF_A must be >= WF_P");
  end
  if (NTAP < 1) begin : gen_chk_ntap
    $error("mac_accfix: NTAP must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e                 state_q, state_d;
  logic signed [WA-1:0]   acc_q, acc_d;
  logic        [TW-1:0]   tap_q, tap_d;
  logic        [WO-1:0]   out_q, out_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;

  logic signed [WA-1:0]   aligned;
  logic signed [WA-1:0]   sum;
  logic signed [WC-1:0]   quant;
  logic                   accept;
  logic                   last_tap;

  always_comb begin
    aligned = WA'($signed(bus.prod)) <<< (WF_A - WF_P);
    // Accumulation wraps modulo 2^WA; only the final sum has to fit.
    sum     = (state_q == StIdle) ? aligned : acc_q + aligned;
    // Arithmetic right shift drops fraction bits with floor rounding.
    quant   = (WC'(sum) <<< LSH) >>> RSH;
  end

  assign accept   = bus.prod_valid && (state_q != StHold);
  assign last_tap = (state_q == StIdle) ? (NTAP == 1) : (tap_q == TW'(NTAP - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    tap_d   = tap_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle, StAcc: begin
        if (accept) begin
          acc_d = sum;
          if (last_tap) begin
            tap_d   = '0;
            valid_d = 1'b1;
            state_d = StHold;
            if (quant > MaxC) begin
              out_d = {1'b0, {(WO - 1){1'b1}}};
              ovf_d = 1'b1;
            end else if (quant < MinC) begin
              out_d = {1'b1, {(WO - 1){1'b0}}};
              ovf_d = 1'b1;
            end else begin
              out_d = quant[WO-1:0];
              ovf_d = 1'b0;
            end
          end else begin
            tap_d   = tap_q + TW'(1);
            state_d = StAcc;
          end
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          acc_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      tap_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.prod_ready = (state_q != StHold);
  assign bus.tap_idx    = tap_q;
  assign bus.out_data   = out_q;
  assign bus.out_valid  = valid_q;
  assign bus.ovf        = ovf_q;
  assign bus.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_mac_accfix.sv
// Bench for mac_accfix at default parameters: directed table vectors, multi-cycle corner
// sequences, and random samples checked against an integer-arithmetic reference.
module tb_mac_accfix;
  typedef logic [11:0] prods_t [4];
  typedef int          gaps_t  [4];
  typedef struct {
    prods_t     p;
    logic [7:0] d;
    logic       o;
  } vec_t;

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  mac_accfix_if #(.WP(12), .WO(8), .TW(2)) bus ();

  mac_accfix dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact sum in 1/256 units, wrapped to 16 bits, floor to 1/16, clamp to 8 bits.
  function automatic void model(input prods_t ps, output logic [7:0] d, output logic o);
    int s;
    int q;
    logic signed [15:0] w;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'($signed(ps[i]));
    w = s[15:0];
    q = int'(w) >>> 4;
    if (q > 127) begin
      d = 8'h7F; o = 1'b1;
    end else if (q < -128) begin
      d = 8'h80; o = 1'b1;
    end else begin
      d = q[7:0]; o = 1'b0;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.prod_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic feed(input logic [11:0] p, input int gaps, input int idx);
    int n;
    for (int g = 0; g < gaps; g++) begin
      bus.prod_valid = 1'b0;
      bus.prod = 12'($urandom);
      tick();
      chk("stall_tap", 32'(bus.tap_idx), 32'(idx));
    end
    bus.prod = p;
    bus.prod_valid = 1'b1;
    n = 0;
    while (!bus.prod_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.prod_ready) chk("ready_timeout", 32'(bus.prod_ready), 32'd1);
    chk("tap_idx", 32'(bus.tap_idx), 32'(idx));
    tick();
    bus.prod_valid = 1'b0;
  endtask

  task automatic run_sample(input prods_t ps, input gaps_t gs, input int holdc,
                            input logic [7:0] ed, input logic eo);
    for (int i = 0; i < 4; i++) feed(ps[i], gs[i], i);
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("out_data", 32'(bus.out_data), 32'(ed));
    chk("ovf", 32'(bus.ovf), 32'(eo));
    chk("hold_tap", 32'(bus.tap_idx), 32'd0);
    chk("hold_ready", 32'(bus.prod_ready), 32'd0);
    if (holdc > 0) begin
      bus.out_ready = 1'b0;
      bus.prod_valid = 1'b1;
      bus.prod = 12'h7FF;
      for (int h = 0; h < holdc; h++) begin
        tick();
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_data", 32'(bus.out_data), 32'(ed));
        chk("bp_ovf", 32'(bus.ovf), 32'(eo));
        chk("bp_ready", 32'(bus.prod_ready), 32'd0);
        chk("bp_tap", 32'(bus.tap_idx), 32'd0);
      end
      bus.prod_valid = 1'b0;
      bus.out_ready = 1'b1;
    end
    tick();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_ready", 32'(bus.prod_ready), 32'd1);
    chk("drain_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vec_t       tbl [5];
    gaps_t      nog;
    prods_t     ps;
    logic [7:0] ed;
    logic       eo;

    tbl[0].p = '{12'h100, 12'h100, 12'h100, 12'h100}; tbl[0].d = 8'h40; tbl[0].o = 1'b0;
    tbl[1].p = '{12'h300, 12'h300, 12'h300, 12'h300}; tbl[1].d = 8'h7F; tbl[1].o = 1'b1;
    tbl[2].p = '{12'hD00, 12'hD00, 12'hD00, 12'hD00}; tbl[2].d = 8'h80; tbl[2].o = 1'b1;
    tbl[3].p = '{12'h00A, 12'h00A, 12'h00A, 12'h00A}; tbl[3].d = 8'h02; tbl[3].o = 1'b0;
    tbl[4].p = '{12'hFF6, 12'hFF6, 12'hFF6, 12'hFF6}; tbl[4].d = 8'hFD; tbl[4].o = 1'b0;
    nog = '{0, 0, 0, 0};

    errs = 0;
    checks = 0;
    bus.prod = '0;
    bus.prod_valid = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_tap", 32'(bus.tap_idx), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.prod_ready), 32'd1);

    for (int v = 0; v < 5; v++) run_sample(tbl[v].p, nog, 0, tbl[v].d, tbl[v].o);

    // Stalls: valid pattern 1,0,0,1,1,0,1.
    run_sample(tbl[0].p, '{0, 2, 0, 1}, 0, 8'h40, 1'b0);

    // Backpressure for 5 cycles, then a normal sample.
    run_sample(tbl[0].p, nog, 5, 8'h40, 1'b0);
    run_sample(tbl[3].p, nog, 0, 8'h02, 1'b0);

    // Next sample accepted two edges after the last accept.
    for (int i = 0; i < 4; i++) feed(12'h100, 0, i);
    bus.prod_valid = 1'b1;
    bus.prod = 12'h100;
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    tick();
    chk("lat_hs_valid", 32'(bus.out_valid), 32'd0);
    chk("lat_hs_tap", 32'(bus.tap_idx), 32'd0);
    tick();
    chk("lat_next_tap", 32'(bus.tap_idx), 32'd1);
    chk("lat_next_busy", 32'(bus.busy), 32'd1);
    do_reset();

    // Reset after two products leaves no residue.
    feed(12'h300, 0, 0);
    feed(12'h300, 0, 1);
    do_reset();
    chk("mid_rst_tap", 32'(bus.tap_idx), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    run_sample(tbl[0].p, nog, 0, 8'h40, 1'b0);

    // Reset while holding a result.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed(12'h300, 0, i);
    chk("hold_pre_valid", 32'(bus.out_valid), 32'd1);
    do_reset();
    chk("hold_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("hold_rst_busy", 32'(bus.busy), 32'd0);
    chk("hold_rst_ready", 32'(bus.prod_ready), 32'd1);
    chk("hold_rst_ovf", 32'(bus.ovf), 32'd0);
    bus.out_ready = 1'b1;

    // Random samples against the reference model.
    for (int r = 0; r < 40; r++) begin
      gaps_t gs;
      for (int i = 0; i < 4; i++) begin
        if (r % 2 == 0) ps[i] = 12'($urandom);
        else            ps[i] = 12'(int'($urandom_range(0, 255)) - 128);
        gs[i] = int'($urandom_range(0, 2));
      end
      model(ps, ed, eo);
      run_sample(ps, gs, int'($urandom_range(0, 3)), ed, eo);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mac_accfix.md
Name: mac_accfix

Overview:
- Time-multiplexed accumulator stage for the FIR datapath. Sits directly downstream of the fixed-point product/add stage.
- Consumes one signed fixed-point product per accepted cycle and sums exactly NTAP products into a wide accumulator.
- Presents the sample result re-quantised to the output format, with saturation and an overflow flag, through a valid/ready handshake.
- Also drives the tap index used upstream to address coefficient and delay-line storage.

Parameters:
- WI_P, 4, integer bits of the product input (sign included)
- WF_P, 8, fractional bits of the product input
- WI_A, 8, integer bits of the accumulator; must be >= WI_P
- WF_A, 8, fractional bits of the accumulator; must be >= WF_P
- WI_O, 4, integer bits of the output
- WF_O, 4, fractional bits of the output
- NTAP, 4, products per output sample; must be >= 1
- Elaboration must fail if WI_A < WI_P, WF_A < WF_P or NTAP < 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- prod  in  WI_P+WF_P  signed product, two's complement
- prod_valid  in  1  prod is valid this cycle
- prod_ready  out  1  block accepts prod this cycle
- tap_idx  out  clog2(NTAP) (min 1)  index of the next product expected, 0..NTAP-1
- out_data  out  WI_O+WF_O  signed result
- out_valid  out  1  out_data/ovf valid
- out_ready  in  1  downstream accepts out_data
- ovf  out  1  result saturated; valid with out_valid
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst=1 at a clock edge forces state=IDLE, acc=0, tap_idx=0, out_data=0, out_valid=0, ovf=0. Reset mid-sample discards the partial sum and any pending output with no flush. Reset has priority over all other events.
- States:
  - IDLE: no partial sum.
  - ACC: 1..NTAP-1 products summed.
  - HOLD: result registered, waiting for out_ready.
- prod_ready = (state != HOLD). It is a registered-state function only, with no combinational path from out_ready.
- A product is accepted on a cycle where prod_valid && prod_ready.
- Alignment: aligned = sign-extend prod by WI_A-WI_P bits, then append WF_A-WF_P zero LSBs.
- Accept in IDLE:
  - acc <= aligned; tap_idx <= 1; go to ACC.
  - If NTAP=1, go directly to HOLD and output from aligned.
- Accept in ACC:
  - acc <= acc + aligned, modulo 2^(WI_A+WF_A). Wrap is intentional: intermediate overflow is benign if the final sum fits.
  - tap_idx increments.
  - On the NTAP-th product, the final sum is quantised into out_data and ovf, out_valid <= 1, tap_idx <= 0, go to HOLD.
- Latency: last product accepted at edge k gives out_valid=1 after edge k.
- Quantisation of final sum S:
  - Fraction: truncate toward minus infinity (drop WF_A-WF_O LSBs), or zero-pad if WF_O > WF_A.
  - Integer: if S is outside [-2^(WI_O-1), 2^(WI_O-1)-2^-WF_O], saturate to the max/min code and set ovf=1; otherwise ovf=0.
  - If WI_O >= WI_A, ovf is constant 0.
- HOLD:
  - out_data, ovf and out_valid stay stable until out_valid && out_ready.
  - On that edge: out_valid <= 0, go to IDLE, and prod_ready is 1 from the next cycle.
  - prod_valid is ignored in HOLD.
- No valid gaps are required. prod_valid low in ACC simply stalls with acc and tap_idx held.
- tap_idx is 0 in IDLE and HOLD.

Test Plan:
- Defaults; four products 0x100 (1.0) back-to-back, out_ready=1 → out_valid one cycle after the 4th accept, out_data=0x40 (4.0), ovf=0. tap_idx sequence 0,1,2,3,0. Next sample accepted 2 cycles after the 4th accept.
- Four products 0x300 (3.0) → out_data=0x7F, ovf=1. Four products 0xD00 (-3.0) → out_data=0x80, ovf=1.
- Truncation: four products 0x00A (+10/256) → out_data=0x02. Four products 0xFF6 (-10/256) → out_data=0xFD (floor of -2.5 LSB).
- Backpressure: out_ready=0 for 5 cycles after result → out_data/ovf/out_valid stable, prod_ready=0, and prod_valid=1 inputs are not consumed. Raise out_ready → handshake, then the next sample proceeds normally.
- Stalls: prod_valid toggling 1,0,0,1,1,0,1 → same result as back-to-back; tap_idx holds during gaps.
- Reset after 2 accepted products, then four 0x100 → out_data=0x40 (no residue). Reset while in HOLD → out_valid=0 on the next cycle, state IDLE.
